// File: rtl/byte_ram_2p.sv
// Simple-dual-port byte-lane RAM: one write port, one read port, 1/2-cycle read latency,
// same-cycle collision forwarding and an optional post-reset zeroing sweep.

module byte_ram_2p_lane #(
    parameter int AW     = 7,
    parameter int BYPASS = 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // A lane being written at the read index forwards the incoming byte when bypass is on.
    assign rdata = ((BYPASS != 0) && we && (waddr == raddr)) ? wdata : mem[raddr];
endmodule

module byte_ram_2p #(
    parameter int DW         = 32,
    parameter int AW         = 7,
    parameter int RD_LAT     = 1,
    parameter int BYPASS     = 1,
    parameter int CLR_ON_RST = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wen,
    input  logic [DW/8-1:0] w_be_i,
    input  logic [31:0]     w_addr_i,
    input  logic [DW-1:0]   w_data_i,
    input  logic            ren,
    input  logic [31:0]     r_addr_i,
    output logic [DW-1:0]   r_data_o,
    output logic            r_valid_o,
    output logic            init_done_o
);
    localparam int NB = DW / 8;

    typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_t;

    state_t                   state;
    logic [AW-1:0]            cnt;
    logic                     init_done_q;
    logic                     clearing;
    logic                     wr_fire;
    logic                     rd_fire;
    logic [AW-1:0]            wr_idx;
    logic [AW-1:0]            rd_idx;
    logic [NB-1:0]            lane_we;
    logic [NB-1:0][7:0]       rd_word;
    logic [DW-1:0]            rd_flat;
    logic [RD_LAT:1]          vld_pipe;
    logic [RD_LAT:1][DW-1:0]  dat_pipe;
    logic                     unused_addr;

    assign unused_addr = ^{w_addr_i[31:AW], r_addr_i[31:AW]};

    assign clearing = (state == S_CLEAR);
    assign wr_fire  = init_done_q && wen;
    assign rd_fire  = init_done_q && ren;
    assign wr_idx   = clearing ? cnt : w_addr_i[AW-1:0];
    assign rd_idx   = r_addr_i[AW-1:0];

    // The sweep owns the write port until the last word is zeroed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= (CLR_ON_RST != 0) ? S_CLEAR : S_READY;
            cnt         <= '0;
            init_done_q <= (CLR_ON_RST == 0);
        end else if (state == S_CLEAR) begin
            cnt <= cnt + 1'b1;
            if (&cnt) begin
                state       <= S_READY;
                init_done_q <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NB; i++) begin : g_lane
        assign lane_we[i] = clearing || (wr_fire && w_be_i[i]);

        byte_ram_2p_lane #(
            .AW     (AW),
            .BYPASS (BYPASS)
        ) u_lane (
            .clk   (clk),
            .we    (lane_we[i]),
            .waddr (wr_idx),
            .wdata (clearing ? 8'h00 : w_data_i[8*i +: 8]),
            .raddr (rd_idx),
            .rdata (rd_word[i])
        );
    end

    assign rd_flat = rd_word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[1] <= rd_fire;
            if (rd_fire) dat_pipe[1] <= rd_flat;
            // Data stages only load on a valid so the output holds between reads.
            for (int s = 2; s <= RD_LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
            end
        end
    end

    assign r_data_o    = dat_pipe[RD_LAT];
    assign r_valid_o   = vld_pipe[RD_LAT];
    assign init_done_o = init_done_q;
endmodule

// File: tb/tb_byte_ram_2p.sv
// Random + directed bench for byte_ram_2p: three instances (lat1/bypass, lat2/no-bypass,
// no-clear) share stimulus and are checked against a word-array reference model.

module tb_byte_ram_2p;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wen = 1'b0;
    logic [3:0]  w_be = '0;
    logic [31:0] w_addr = '0;
    logic [31:0] w_data = '0;
    logic        ren = 1'b0;
    logic [31:0] r_addr = '0;

    logic [31:0] r_data1, r_data2, r_data3;
    logic        r_valid1, r_valid2, r_valid3;
    logic        done1, done2, done3;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    byte_ram_2p #(.DW(32), .AW(7), .RD_LAT(1), .BYPASS(1), .CLR_ON_RST(1)) dut1 (
        .clk(clk), .rst(rst), .wen(wen), .w_be_i(w_be), .w_addr_i(w_addr), .w_data_i(w_data),
        .ren(ren), .r_addr_i(r_addr), .r_data_o(r_data1), .r_valid_o(r_valid1), .init_done_o(done1));

    byte_ram_2p #(.DW(32), .AW(7), .RD_LAT(2), .BYPASS(0), .CLR_ON_RST(1)) dut2 (
        .clk(clk), .rst(rst), .wen(wen), .w_be_i(w_be), .w_addr_i(w_addr), .w_data_i(w_data),
        .ren(ren), .r_addr_i(r_addr), .r_data_o(r_data2), .r_valid_o(r_valid2), .init_done_o(done2));

    byte_ram_2p #(.DW(32), .AW(7), .RD_LAT(1), .BYPASS(1), .CLR_ON_RST(0)) dut3 (
        .clk(clk), .rst(rst), .wen(wen), .w_be_i(w_be), .w_addr_i(w_addr), .w_data_i(w_data),
        .ren(ren), .r_addr_i(r_addr), .r_data_o(r_data3), .r_valid_o(r_valid3), .init_done_o(done3));

    // Reference model: memory as plain words, readiness as edges elapsed since reset release.
    logic [31:0] ref_mem [128];
    int          clr_edges;
    bit          e1_v, e2_v, e3_v, p_v;
    logic [31:0] e1_d, e2_d, p_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (ref_mem[k]) ref_mem[k] = '0;
        clr_edges = 0;
        e1_v = 0; e2_v = 0; e3_v = 0; p_v = 0;
        e1_d = '0; e2_d = '0; p_d = '0;
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        wen = 0; ren = 0; w_be = '0; w_addr = '0; w_data = '0; r_addr = '0;
        rst = 0;
        #1;
        chk("rst_v1", 32'(r_valid1), 32'd0);
        chk("rst_d1", r_data1, 32'd0);
        chk("rst_v2", 32'(r_valid2), 32'd0);
        chk("rst_d2", r_data2, 32'd0);
        chk("rst_done1", 32'(done1), 32'd0);
        chk("rst_done2", 32'(done2), 32'd0);
        chk("rst_done3", 32'(done3), 32'd1);
        repeat (hold) @(negedge clk);
        rst = 1;
        model_reset();
    endtask

    // Drive one cycle of stimulus, predict the edge, then check all outputs after it.
    task automatic step(input bit w, input logic [3:0] be, input logic [31:0] wa,
                        input logic [31:0] wd, input bit r, input logic [31:0] ra);
        logic [31:0] old_w, byp_w;
        bit          rdy;
        int          wi, ri;
        wen = w; w_be = be; w_addr = wa; w_data = wd; ren = r; r_addr = ra;
        rdy = (clr_edges >= 128);
        wi  = int'(wa % 128);
        ri  = int'(ra % 128);
        old_w = ref_mem[ri];
        byp_w = old_w;
        if (w && rdy && wi == ri)
            for (int b = 0; b < 4; b++) if (be[b]) byp_w[8*b +: 8] = wd[8*b +: 8];
        e2_v = p_v;
        if (p_v) e2_d = p_d;
        p_v = r && rdy;
        if (p_v) p_d = old_w;
        e1_v = r && rdy;
        if (e1_v) e1_d = byp_w;
        e3_v = r;
        if (w && rdy)
            for (int b = 0; b < 4; b++) if (be[b]) ref_mem[wi][8*b +: 8] = wd[8*b +: 8];
        if (clr_edges < 128) clr_edges++;
        @(posedge clk);
        @(negedge clk);
        chk("valid1", 32'(r_valid1), 32'(e1_v));
        chk("data1", r_data1, e1_d);
        chk("valid2", 32'(r_valid2), 32'(e2_v));
        chk("data2", r_data2, e2_d);
        chk("done1", 32'(done1), 32'(clr_edges >= 128));
        chk("done2", 32'(done2), 32'(clr_edges >= 128));
        chk("valid3", 32'(r_valid3), 32'(e3_v));
        chk("done3", 32'(done3), 32'd1);
    endtask

    task automatic rnd_step(input int addr_span);
        logic [31:0] wa, ra;
        wa = ($urandom & 32'hFFFF_FF80) | 32'($urandom_range(0, addr_span - 1));
        ra = ($urandom & 32'hFFFF_FF80) | 32'($urandom_range(0, addr_span - 1));
        step(1'($urandom), 4'($urandom), wa, $urandom, 1'($urandom), ra);
    endtask

    initial begin
        model_reset();
        do_reset(3);

        // Abort the sweep part way, then let a full sweep run under random traffic.
        repeat (40) rnd_step(128);
        do_reset(2);
        repeat (128) rnd_step(128);

        step(0, 4'h0, 0, 0, 1, 32'd0);   chk("t1_idx0", r_data1, 32'h0);
        step(0, 4'h0, 0, 0, 1, 32'd64);  chk("t1_idx64", r_data1, 32'h0);
        step(0, 4'h0, 0, 0, 1, 32'd127); chk("t1_idx127", r_data1, 32'h0);

        step(1, 4'hF, 32'd5, 32'hAABBCCDD, 0, 0);
        step(1, 4'h5, 32'd5, 32'h11223344, 0, 0);
        step(0, 4'h0, 0, 0, 1, 32'd5);   chk("t2_lanes", r_data1, 32'hAA22CC44);

        step(1, 4'hF, 32'd9, 32'hAA22CC44, 0, 0);
        step(1, 4'h3, 32'd9, 32'h11223344, 1, 32'd9); chk("t3_byp", r_data1, 32'hAA223344);
        step(0, 4'h0, 0, 0, 0, 0);                    chk("t3_nobyp", r_data2, 32'hAA22CC44);
        step(0, 4'h0, 0, 0, 1, 32'd9);                chk("t3_after1", r_data1, 32'hAA223344);
        step(0, 4'h0, 0, 0, 0, 0);
        step(0, 4'h0, 0, 0, 0, 0);                    chk("t3_after2", r_data2, 32'hAA223344);

        step(1, 4'hF, 32'd1, 32'h01010101, 0, 0);
        step(1, 4'hF, 32'd2, 32'h02020202, 0, 0);
        step(1, 4'hF, 32'd3, 32'h03030303, 0, 0);
        step(0, 4'h0, 0, 0, 1, 32'd1); chk("t4_v0", 32'(r_valid2), 32'd0);
        step(0, 4'h0, 0, 0, 1, 32'd2); chk("t4_d1", r_data2, 32'h01010101);
        step(0, 4'h0, 0, 0, 1, 32'd3); chk("t4_d2", r_data2, 32'h02020202);
        step(0, 4'h0, 0, 0, 0, 0);     chk("t4_d3", r_data2, 32'h03030303);
        step(0, 4'h0, 0, 0, 0, 0);     chk("t4_vend", 32'(r_valid2), 32'd0);

        step(1, 4'hF, 32'h80, 32'h5, 0, 0);
        step(0, 4'h0, 0, 0, 1, 32'h0); chk("t5_wrap", r_data1, 32'h5);

        // Narrow index range so collisions and rewrites are frequent.
        repeat (500) rnd_step(8);
        repeat (200) rnd_step(128);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
